// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with self-generated phase.
// Latency: 1 cycle from an accepted sample to its registered output.
// Backpressure: none; di_en gaps freeze all state and hold the data outputs.
module r2sdf_stage #(
    parameter int WIDTH       = 16,
    parameter int DELAY_DEPTH = 1,
    parameter int SCALE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic             do_sof,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int CW = $clog2(2 * DELAY_DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } cplx_t;

    logic [CW-1:0] cnt;
    logic          primed;
    logic          phase;
    cplx_t         dl [DELAY_DEPTH];
    cplx_t         dl_out;
    cplx_t         dl_in;
    cplx_t         result;
    logic [WIDTH:0] sum_re, sum_im, dif_re, dif_im;

    // Reduce a WIDTH+1 bit butterfly result back to WIDTH bits.
    function automatic logic [WIDTH-1:0] fit(input logic [WIDTH:0] v);
        if (SCALE != 0)
            return v[WIDTH:1];
        else if (v[WIDTH] != v[WIDTH-1])
            return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            return v[WIDTH-1:0];
    endfunction

    assign phase  = cnt[CW-1];
    assign dl_out = dl[DELAY_DEPTH-1];

    assign sum_re = {dl_out.re[WIDTH-1], dl_out.re} + {di_re[WIDTH-1], di_re};
    assign sum_im = {dl_out.im[WIDTH-1], dl_out.im} + {di_im[WIDTH-1], di_im};
    assign dif_re = {dl_out.re[WIDTH-1], dl_out.re} - {di_re[WIDTH-1], di_re};
    assign dif_im = {dl_out.im[WIDTH-1], dl_out.im} - {di_im[WIDTH-1], di_im};

    // Phase 0 drains the previous frame's differences while filling the line.
    always_comb begin
        result    = dl_out;
        dl_in.re  = di_re;
        dl_in.im  = di_im;
        if (phase) begin
            result.re = fit(sum_re);
            result.im = fit(sum_im);
            dl_in.re  = fit(dif_re);
            dl_in.im  = fit(dif_im);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            primed <= 1'b0;
            do_en  <= 1'b0;
            do_sof <= 1'b0;
            do_re  <= '0;
            do_im  <= '0;
            for (int i = 0; i < DELAY_DEPTH; i++)
                dl[i] <= '0;
        end else if (di_en) begin
            cnt    <= cnt + CW'(1);
            primed <= primed | phase;
            do_en  <= primed | phase;
            do_sof <= phase && (cnt == CW'(DELAY_DEPTH));
            do_re  <= result.re;
            do_im  <= result.im;
            dl[0]  <= dl_in;
            for (int i = 1; i < DELAY_DEPTH; i++)
                dl[i] <= dl[i-1];
        end else begin
            do_en  <= 1'b0;
            do_sof <= 1'b0;
        end
    end

endmodule

// File: doc/r2sdf_stage.md
Name: r2sdf_stage

Overview:
Parametrised radix-2 single-path delay-feedback (R2SDF) butterfly stage for the streaming FFT pipeline.
- Generates its own butterfly phase from an internal sample counter, so no external select is needed.
- Accepts an input-enable handshake that tolerates gaps in the stream.
- Supports per-stage scaling or saturation, and marks the first output of each frame.
- Stages chain directly (do_* to di_*), with twiddle multipliers placed between stages.

Parameters:
WIDTH, 16, two's-complement bit width of each real/imag sample (input and output)
DELAY_DEPTH, 1, feedback delay length D in samples; power of two, >= 1
SCALE, 0, 1 = arithmetic shift right by 1 of butterfly results; 0 = saturate to WIDTH bits

Ports:
clk  in  1  master clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
di_en  in  1  input sample valid; sample accepted on every clk edge where di_en=1
di_re  in  WIDTH  input data, real
di_im  in  WIDTH  input data, imag
do_en  out  1  output sample valid
do_sof  out  1  high with the first sum output of each 2D-sample frame
do_re  out  WIDTH  output data, real
do_im  out  WIDTH  output data, imag

Behaviour:
- Reset values: do_en=0, do_sof=0, do_re=0, do_im=0. Counter, primed flag and all delay-line entries are cleared to 0. Reset is synchronous and active-high, and wins over di_en in the same cycle.
- Counter: cnt is log2(2D) bits wide and increments by 1 on each accepted sample, wrapping at 2D-1 to 0. phase = cnt MSB (for D=1, phase = cnt).
- Delay line: D-entry complex shift register that advances only on accepted samples. dl_out is the oldest entry.
- Phase 0 (accepted sample x):
  - dl_in = x
  - result = dl_out (the pending difference from the previous frame)
- Phase 1 (accepted sample x, with a = dl_out):
  - result = a + x
  - dl_in = a - x
- Arithmetic:
  - Compute sum and difference in WIDTH+1 bits.
  - SCALE=1: take bits [WIDTH:1] (arithmetic shift right, truncation toward -inf).
  - SCALE=0: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - The same rule applies to the difference before it enters the delay line.
  - Real and imaginary parts are processed independently.
- primed flag: set on the first accepted phase-1 sample; cleared only by reset.
- Output timing: registered, 1-cycle latency. On the edge accepting sample n:
  - do_re/do_im <= result
  - do_en <= primed_next (primed_next = primed, or this sample is phase 1)
  - do_sof <= 1 iff this sample is phase 1 with cnt = D (first sum of the frame)
  - On edges with di_en=0: do_en<=0, do_sof<=0, do_re/do_im hold.
- Output order per frame: D sums x[k]+x[k+D], then, during the next frame's phase 0, D differences x[k]-x[k+D]. The stream is offset by D samples.
- End of stream: the last D differences stay in the delay line. Upstream flushes them with D accepted zero samples; the outputs during those samples are the differences.
- Gaps: idle cycles (di_en=0) freeze the counter, delay line, primed flag and data outputs. The output sequence is independent of gap placement.
- Mid-frame reset: the partial frame is discarded. The next accepted sample is treated as cnt=0, and do_en stays low until the next phase-1 sample.

Test Plan:
1. D=1, WIDTH=16, SCALE=0, continuous di_en, re inputs 1,2,3,4 then one flush 0, im=0 -> do_en=1 outputs re 3,-1,7,-1, one cycle after inputs 2,3,4,flush. do_sof=1 with 3 and 7. No do_en on the first input.
2. D=4, ramp re 0..7 then 4 zeros -> sums 4,6,8,10 (do_sof on 4), then differences -4,-4,-4,-4. im all 0.
3. Saturation, D=1, SCALE=0: pair (30000,30000) -> sum 32767, diff 0. Pair (-30000,30000) -> sum 0, diff -32768. Same checks on the im path.
4. Scaling, D=1, SCALE=1: pair (7,2) -> sum 4, diff 2. Pair (-3,0) -> sum -2, diff -2.
5. Gaps, D=4: same stimulus as test 2 with random 0-3 idle cycles between samples -> identical do_re/do_im/do_sof sequence on do_en cycles. do_en=0 on every idle-following cycle.
6. Reset asserted after 3 samples of a D=4 frame, then ramp 0..7 plus flush -> do_en stays 0 until the 5th post-reset sample, then outputs match test 2 exactly.
